// File: rtl/miner_wb_regfile.sv
// -----------------------------------------------------------------------------
// miner_wb_regfile
//   Wishbone-classic slave register file between the management SoC and the
//   SHA-256d hashing core. Holds the work unit (midstate, header tail, nonce
//   range), issues start/stop pulses to the core and buffers found nonces in
//   a small FIFO that firmware pops by reading RESULT.
//
// Ports
//   wb_clk, wb_rst_n      clock, synchronous active-low reset
//   wb_cycle/strobe/we    Wishbone classic request qualifiers
//   wb_sel[3:0]           byte lane selects
//   wb_addr[7:0]          byte address (bits [1:0] ignored)
//   wb_wdata[31:0]        write data
//   wb_ack                registered acknowledge, one cycle wide
//   wb_rdata[31:0]        read data, valid while wb_ack=1
//   midstate[255:0]       MIDSTATE7..0, word 0 in [31:0]
//   header_tail[95:0]     DATA2..0, word 0 in [31:0]
//   nonce_start/end       inclusive nonce range
//   work_start/stop       one-cycle pulses to the core
//   core_busy             core is hashing
//   nonce_valid, nonce    found-nonce strobe and value
//   irq                   registered interrupt
//
// Handshake: a request is wb_cycle & wb_strobe & !wb_ack. The request edge
// raises wb_ack, commits any write and loads wb_rdata; wb_ack drops on the
// next edge, so a held strobe yields at most one ack every other cycle.
// -----------------------------------------------------------------------------
module miner_wb_regfile #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'h4254_4331
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  input  logic         wb_cycle,
  input  logic         wb_strobe,
  input  logic         wb_we,
  input  logic [3:0]   wb_sel,
  input  logic [7:0]   wb_addr,
  input  logic [31:0]  wb_wdata,
  output logic         wb_ack,
  output logic [31:0]  wb_rdata,
  output logic [255:0] midstate,
  output logic [95:0]  header_tail,
  output logic [31:0]  nonce_start,
  output logic [31:0]  nonce_end,
  output logic         work_start,
  output logic         work_stop,
  input  logic         core_busy,
  input  logic         nonce_valid,
  input  logic [31:0]  nonce,
  output logic         irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Word indices (byte offset / 4)
  localparam logic [5:0] A_DATA0  = 6'd8;
  localparam logic [5:0] A_DATA1  = 6'd9;
  localparam logic [5:0] A_DATA2  = 6'd10;
  localparam logic [5:0] A_NSTART = 6'd11;
  localparam logic [5:0] A_NEND   = 6'd12;
  localparam logic [5:0] A_CTRL   = 6'd13;
  localparam logic [5:0] A_STATUS = 6'd14;
  localparam logic [5:0] A_RESULT = 6'd15;
  localparam logic [5:0] A_ID     = 6'd16;

  logic [31:0]   r_midstate [8];
  logic [31:0]   r_data     [3];
  logic [31:0]   r_nonce_start;
  logic [31:0]   r_nonce_end;
  logic          r_irq_en;
  logic          r_overflow;
  logic [31:0]   r_fifo     [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_req;
  logic          w_wr;
  logic          w_rd;
  logic [5:0]    w_word;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_ctrl_wr;
  logic [7:0]    w_count8;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_mux;
  logic          w_unused;

  // Address bits [1:0] carry no meaning for word registers.
  assign w_unused = ^wb_addr[1:0];

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_req  = wb_cycle & wb_strobe & ~wb_ack;
  assign w_wr   = w_req & wb_we;
  assign w_rd   = w_req & ~wb_we;
  assign w_word = wb_addr[7:2];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when it coincides with a RESULT read.
  assign w_pop     = w_rd & (w_word == A_RESULT) & ~w_empty;
  assign w_push    = nonce_valid & (~w_full | w_pop);
  assign w_ovf_set = nonce_valid & w_full & ~w_pop;

  assign w_ctrl_wr = w_wr & (w_word == A_CTRL) & wb_sel[0];
  assign w_ovf_clr = w_wr & (w_word == A_STATUS) & wb_sel[0] & wb_wdata[3];

  assign w_count8 = 8'(r_count);
  assign w_status = {16'b0, w_count8, 4'b0, r_overflow, w_full, w_empty, core_busy};

  always_comb begin
    w_rd_mux = '0;
    if (w_word < A_DATA0) begin
      w_rd_mux = r_midstate[w_word[2:0]];
    end else begin
      case (w_word)
        A_DATA0:  w_rd_mux = r_data[0];
        A_DATA1:  w_rd_mux = r_data[1];
        A_DATA2:  w_rd_mux = r_data[2];
        A_NSTART: w_rd_mux = r_nonce_start;
        A_NEND:   w_rd_mux = r_nonce_end;
        A_CTRL:   w_rd_mux = {29'b0, r_irq_en, 2'b0};
        A_STATUS: w_rd_mux = w_status;
        A_RESULT: w_rd_mux = w_empty ? 32'h0 : r_fifo[r_rptr];
        A_ID:     w_rd_mux = ID_VALUE;
        default:  w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < 8; i++) r_midstate[i] <= '0;
      for (int i = 0; i < 3; i++) r_data[i] <= '0;
      r_nonce_start <= '0;
      r_nonce_end   <= '0;
      r_irq_en      <= 1'b0;
      r_overflow    <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      wb_ack        <= 1'b0;
      wb_rdata      <= '0;
      work_start    <= 1'b0;
      work_stop     <= 1'b0;
      irq           <= 1'b0;
    end else begin
      wb_ack <= w_req;
      if (w_req) wb_rdata <= w_rd_mux;

      // STOP wins over START; START is dropped while the core is busy.
      work_start <= w_ctrl_wr & wb_wdata[0] & ~wb_wdata[1] & ~core_busy;
      work_stop  <= w_ctrl_wr & wb_wdata[1];

      irq <= r_irq_en & (~w_empty | r_overflow);

      if (w_wr) begin
        if (w_word < A_DATA0) begin
          r_midstate[w_word[2:0]] <= f_merge(r_midstate[w_word[2:0]], wb_wdata, wb_sel);
        end else begin
          case (w_word)
            A_DATA0:  r_data[0]     <= f_merge(r_data[0], wb_wdata, wb_sel);
            A_DATA1:  r_data[1]     <= f_merge(r_data[1], wb_wdata, wb_sel);
            A_DATA2:  r_data[2]     <= f_merge(r_data[2], wb_wdata, wb_sel);
            A_NSTART: r_nonce_start <= f_merge(r_nonce_start, wb_wdata, wb_sel);
            A_NEND:   r_nonce_end   <= f_merge(r_nonce_end, wb_wdata, wb_sel);
            default:  ;
          endcase
        end
      end

      if (w_ctrl_wr) r_irq_en <= wb_wdata[2];

      // A new overflow on the clearing edge keeps the flag set.
      r_overflow <= (r_overflow & ~w_ovf_clr) | w_ovf_set;

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge wb_clk) begin
    if (w_push) r_fifo[r_wptr] <= nonce;
  end

  always_comb begin
    midstate = '0;
    for (int i = 0; i < 8; i++) midstate[32*i +: 32] = r_midstate[i];
    header_tail = {r_data[2], r_data[1], r_data[0]};
  end

  assign nonce_start = r_nonce_start;
  assign nonce_end   = r_nonce_end;

endmodule

// File: doc/miner_wb_regfile.md
Name: miner_wb_regfile

Overview:
- Wishbone-classic slave register file that sits between the management SoC Wishbone port and the SHA-256d hashing core of the miner.
- Holds the work unit (midstate, header tail, nonce range) and issues start/stop pulses to the core.
- Buffers found nonces from the core in a small FIFO that firmware pops over Wishbone.
- Single clock domain (wb_clk); the core side is assumed synchronous to wb_clk.

Parameters:
- FIFO_DEPTH, 8, result FIFO entries; power of 2, 2..64
- ID_VALUE, 32'h4254_4331, constant returned by the ID register

Ports:
- wb_clk  in  1  Wishbone and block clock
- wb_rst_n  in  1  synchronous active-low reset
- wb_cycle  in  1  Wishbone cycle
- wb_strobe  in  1  Wishbone strobe
- wb_we  in  1  write enable
- wb_sel  in  4  byte selects
- wb_addr  in  8  byte address; bits [1:0] ignored
- wb_wdata  in  32  write data
- wb_ack  out  1  transfer acknowledge
- wb_rdata  out  32  read data, valid while wb_ack=1
- midstate  out  256  MIDSTATE7..0 concatenated; word 0 in bits [31:0]
- header_tail  out  96  DATA2..0 concatenated; word 0 in bits [31:0]
- nonce_start  out  32  first nonce
- nonce_end  out  32  last nonce, inclusive
- work_start  out  1  one-cycle start pulse to the core
- work_stop  out  1  one-cycle abort pulse to the core
- core_busy  in  1  core is hashing
- nonce_valid  in  1  one-cycle found-nonce strobe
- nonce  in  32  found nonce, qualified by nonce_valid
- irq  out  1  registered interrupt

Behaviour:
- Reset (wb_rst_n=0 at a clock edge) clears all RW registers, IRQ_EN, the overflow flag, the FIFO pointers and count, wb_ack, wb_rdata, work_start, work_stop and irq to 0.
- Reset asserted mid-transfer drops the pending ack; the master must restart the transfer.
- Wishbone handshake:
  - A request is wb_cycle & wb_strobe & !wb_ack.
  - wb_ack is registered: it goes high the cycle after the request and low the following cycle, so it is never high for two consecutive cycles.
  - Writes commit on the same edge that raises wb_ack; wb_rdata updates on that edge too.
  - Every address is acked; there are no errors and no wait states beyond one cycle.
- Register map (byte offsets):
  - 0x00-0x1C MIDSTATE0-7, RW.
  - 0x20-0x28 DATA0-2, RW.
  - 0x2C NONCE_START, RW.
  - 0x30 NONCE_END, RW.
  - 0x34 CTRL:
    - bit0 START, write-1 pulse.
    - bit1 STOP, write-1 pulse.
    - bit2 IRQ_EN, RW.
    - Reads return {29'b0, IRQ_EN, 2'b0}.
  - 0x38 STATUS:
    - bit0 core_busy, RO.
    - bit1 fifo_empty, RO.
    - bit2 fifo_full, RO.
    - bit3 overflow, sticky; write 1 to clear.
    - [15:8] count, RO.
  - 0x3C RESULT, RO; a read pops the FIFO.
  - 0x40 ID, RO, returns ID_VALUE.
  - Unmapped addresses read 0; writes to them are ignored.
- Byte lanes: RW registers honour wb_sel per byte lane.
  - CTRL and STATUS act only if wb_sel[0]=1.
- START:
  - If core_busy=0, work_start pulses high for exactly one cycle, the cycle after the write edge.
  - If core_busy=1, START is ignored.
- STOP: work_stop pulses for one cycle unconditionally.
- START and STOP written together: STOP wins; only work_stop pulses.
- Work registers remain writable while core_busy=1; the core latches them on work_start.
- FIFO push:
  - nonce_valid=1 and not full: push nonce.
  - nonce_valid=1 and full: drop nonce and set overflow, unless a pop occurs on the same edge; in that case the push is accepted and count is unchanged.
- FIFO pop:
  - A RESULT read while count>0 returns the head entry and pops on the ack edge.
  - A RESULT read while empty returns 32'h0 and leaves the pointers unchanged; a simultaneous push still occurs.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Order is first in, first out.
- irq is registered: irq <= IRQ_EN & (count != 0 | overflow); it is 1-cycle delayed.
- Overflow clear and a new overflow on the same edge: overflow stays set.

Test Plan:
- Write 0x0000_0000 to 0x34 after reset, then read 0x40 and 0x38 -> 0x4254_4331; STATUS 0x0000_0002; each ack is exactly 1 cycle wide, 1 cycle after strobe.
- Write MIDSTATE0=0x6A09E667 with wb_sel=4'b0011, then wb_sel=4'b1111 writing 0xFFFF_FFFF to 0x20 -> midstate[31:0]=0x0000E667; header_tail[31:0]=0xFFFFFFFF.
- Write 0x1 to CTRL with core_busy=0 -> work_start=1 for one cycle. Repeat with core_busy=1 -> no pulse. Write 0x3 -> only work_stop pulses.
- Push nonces 1..8 (FIFO_DEPTH=8), then push 9 -> STATUS=0x0000_080C. Read RESULT 8 times -> 1..8 in order; the 9th read returns 0. Write 0x8 to STATUS -> overflow cleared.
- Fill FIFO to 8, then nonce_valid=1 (nonce=0xAA) coincident with a RESULT pop ack -> no overflow, count stays 8, 0xAA is read last.
- Set IRQ_EN=1, push one nonce -> irq=1 one cycle later. Pop it -> irq returns to 0. Assert wb_rst_n=0 mid-transfer -> wb_ack=0 and all outputs return to 0.
